// File: rtl/dcache_wb_dm.sv
// dcache_wb_dm -- direct-mapped, write-back, write-allocate data cache.
//
// Sits between the core's 32-bit word port and a slow line-wide memory.
// Hits are served in the same cycle; a miss stalls the core while the
// victim line is written back (when dirty) and the new line is fetched.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   proc_read/write     core word request (both high behaves as a write)
//   proc_addr[29:0]     word address: [1:0] offset, [INDEX_W+1:2] index, rest tag
//   proc_wdata/rdata    core write / read data (rdata valid when not stalled)
//   proc_stall          core must hold its request while high
//   mem_read/write      line request to slow memory (never both high)
//   mem_addr[27:0]      line address
//   mem_wdata/rdata     128-bit line, word 0 in [31:0]
//   mem_ready           one-cycle completion pulse from slow memory
module dcache_wb_dm #(
   parameter int INDEX_W = 3,
   parameter int TAG_W   = 25
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         proc_read,
   input  logic         proc_write,
   input  logic [29:0]  proc_addr,
   input  logic [31:0]  proc_wdata,
   output logic [31:0]  proc_rdata,
   output logic         proc_stall,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready
);
   localparam int LINES = 1 << INDEX_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

   state_t             state_reg;
   logic [LINES-1:0]   valid_reg;
   logic [LINES-1:0]   dirty_reg;
   logic [TAG_W-1:0]   tag_arr [LINES];

   logic [INDEX_W-1:0] idx;
   logic [1:0]         off;
   logic [TAG_W-1:0]   tag;
   logic [127:0]       line_rd;
   logic               req;
   logic               hit;
   logic               wr_hit;
   logic               fill;

   assign idx = proc_addr[INDEX_W+1:2];
   assign off = proc_addr[1:0];
   assign tag = proc_addr[29:INDEX_W+2];

   assign req    = proc_read | proc_write;
   assign hit    = valid_reg[idx] && (tag_arr[idx] == tag);
   // rst_n gating keeps a reset pulse from landing a write on the arrays.
   assign wr_hit = rst_n && (state_reg == IDLE) && proc_write && hit;
   assign fill   = rst_n && (state_reg == ALLOCATE) && mem_ready;

   // One word-wide bank per offset so a write hit touches a single word
   // while a fill writes all four at once.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bank
         logic [31:0] bank [LINES];

         always_ff @(posedge clk) begin
            if (fill)
               bank[idx] <= mem_rdata[gi*32 +: 32];
            else if (wr_hit && (off == 2'(gi)))
               bank[idx] <= proc_wdata;
         end

         assign line_rd[gi*32 +: 32] = bank[idx];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (fill)
         tag_arr[idx] <= tag;
   end

   // Hit data and stall are combinational so a hit costs no cycle.
   assign proc_rdata = (rst_n && (state_reg == IDLE) && proc_read && hit)
                       ? line_rd[{off, 5'b0} +: 32] : 32'd0;
   assign proc_stall = rst_n && ((state_reg != IDLE) || (req && !hit));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         valid_reg <= '0;
         dirty_reg <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req) begin
                  if (hit) begin
                     if (proc_write)
                        dirty_reg[idx] <= 1'b1;
                  end else if (valid_reg[idx] && dirty_reg[idx]) begin
                     state_reg <= WRITEBACK;
                     mem_write <= 1'b1;
                     mem_addr  <= {tag_arr[idx], idx};
                     mem_wdata <= line_rd;
                  end else begin
                     state_reg <= ALLOCATE;
                     mem_read  <= 1'b1;
                     mem_addr  <= proc_addr[29:2];
                  end
               end
            end
            WRITEBACK: begin
               if (mem_ready) begin
                  state_reg <= ALLOCATE;
                  mem_write <= 1'b0;
                  mem_read  <= 1'b1;
                  mem_addr  <= proc_addr[29:2];
               end
            end
            ALLOCATE: begin
               if (mem_ready) begin
                  state_reg      <= IDLE;
                  mem_read       <= 1'b0;
                  valid_reg[idx] <= 1'b1;
                  dirty_reg[idx] <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_wb_dm.sv
// Bench for dcache_wb_dm: a flat word-addressed golden memory plus a
// per-index tag table predict hits, stall lengths, write-back contents and
// read data; a slow-memory responder with programmable latency serves lines.
module tb_dcache_wb_dm;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         proc_read = 1'b0;
   logic         proc_write = 1'b0;
   logic [29:0]  proc_addr = '0;
   logic [31:0]  proc_wdata = '0;
   logic [31:0]  proc_rdata;
   logic         proc_stall;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata = '0;
   logic         mem_ready = 1'b0;

   dcache_wb_dm dut (
      .clk(clk), .rst_n(rst_n),
      .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
      .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .proc_stall(proc_stall),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int mem_lat = 1;
   bit spurious = 0;
   bit mon_en = 0;

   logic [127:0] smem [logic [27:0]];
   logic [31:0]  golden [logic [29:0]];
   bit           m_valid [8];
   bit           m_dirty [8];
   logic [24:0]  m_tag [8];

   int           n_rd, n_wr, op_cyc;
   logic [31:0]  op_rdata;
   logic [27:0]  last_rd_addr, last_wr_addr;
   logic [127:0] last_wr_data;
   logic [2:0]   mi;
   logic [29:0]  ra;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [29:0] a);
      return 32'hA000_0000 ^ {2'b00, a};
   endfunction

   function automatic logic [127:0] mem_line(input logic [27:0] la);
      logic [127:0] l;
      if (smem.exists(la)) return smem[la];
      for (int w = 0; w < 4; w++) l[w*32 +: 32] = init_word({la, 2'(w)});
      return l;
   endfunction

   function automatic logic [31:0] gold_word(input logic [29:0] a);
      logic [127:0] l;
      if (golden.exists(a)) return golden[a];
      l = mem_line(a[29:2]);
      return l[{a[1:0], 5'b0} +: 32];
   endfunction

   function automatic logic [127:0] gold_line(input logic [27:0] la);
      logic [127:0] l;
      for (int w = 0; w < 4; w++) l[w*32 +: 32] = gold_word({la, 2'(w)});
      return l;
   endfunction

   // Slow memory: answers a pending request after mem_lat cycles.
   initial begin
      int cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         mem_ready = 1'b0;
         if (!rst_n) begin
            cnt = 0;
         end else if (mem_read || mem_write) begin
            cnt++;
            if (cnt >= mem_lat) begin
               cnt = 0;
               mem_ready = 1'b1;
               if (mem_write) smem[mem_addr] = mem_wdata;
               else mem_rdata = mem_line(mem_addr);
            end
         end else if (spurious) begin
            spurious = 0;
            mem_ready = 1'b1;
            mem_rdata = {4{32'hBAD0_BAD0}};
         end
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         chk("overlap", {mem_read, mem_write} == 2'b11, 1'b0);
         if (mem_write) begin
            mi = proc_addr[4:2];
            chk("wb_addr", mem_addr, {m_tag[mi], mi});
            chk("wb_data", mem_wdata, gold_line({m_tag[mi], mi}));
         end
         if (mem_read) chk("fill_addr", mem_addr, proc_addr[29:2]);
         if (mem_ready && mem_read) begin n_rd++; last_rd_addr = mem_addr; end
         if (mem_ready && mem_write) begin
            n_wr++; last_wr_addr = mem_addr; last_wr_data = mem_wdata;
         end
         if (proc_read && !proc_write && !proc_stall)
            chk("rdata", proc_rdata, gold_word(proc_addr));
         if (!proc_read && !proc_write)
            chk("idle", {proc_stall, mem_read, mem_write}, 3'b000);
      end
   end

   // Entered and left at posedge+1.
   task automatic do_op(input bit wr, input logic [29:0] a, input logic [31:0] d);
      logic [2:0] i;
      bit h, vd;
      int exp_cyc, cyc;
      i  = a[4:2];
      h  = m_valid[i] && (m_tag[i] == a[29:5]);
      vd = m_valid[i] && m_dirty[i];
      exp_cyc = h ? 0 : (vd ? 1 + 2*mem_lat : 1 + mem_lat);
      n_rd = 0; n_wr = 0;
      proc_addr = a; proc_read = !wr; proc_write = wr; proc_wdata = d;
      @(negedge clk);
      chk("stall_first", proc_stall, !h);
      cyc = 0;
      while (proc_stall && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      op_cyc = cyc;
      op_rdata = proc_rdata;
      chk("miss_cycles", cyc, exp_cyc);
      chk("n_rd", n_rd, h ? 0 : 1);
      chk("n_wr", n_wr, (!h && vd) ? 1 : 0);
      if (!wr) chk("op_rdata", proc_rdata, gold_word(a));
      @(posedge clk);
      #1;
      if (wr) golden[a] = d;
      if (!h) begin m_valid[i] = 1; m_tag[i] = a[29:5]; m_dirty[i] = 0; end
      if (wr) m_dirty[i] = 1;
      proc_read = 0; proc_write = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", proc_stall, 1'b0);
      chk("rst_rdata", proc_rdata, 32'd0);
      chk("rst_mem", {mem_read, mem_write, mem_addr}, 30'd0);
      chk("rst_wdata", mem_wdata, 128'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1;

      // Cold read, then hits and a write hit on line 4.
      mem_lat = 3;
      do_op(0, 30'h10, 32'd0);
      chk("cold_rdata", op_rdata, 32'hA000_0010);
      chk("cold_addr", last_rd_addr, 28'h4);
      chk("cold_cyc", op_cyc, 4);
      do_op(0, 30'h12, 32'd0);
      chk("hit_rdata", op_rdata, 32'hA000_0012);
      chk("hit_cyc", op_cyc, 0);
      do_op(1, 30'h11, 32'hDEAD_BEEF);
      chk("whit_traffic", n_rd + n_wr, 0);
      do_op(0, 30'h11, 32'd0);
      chk("whit_rdata", op_rdata, 32'hDEAD_BEEF);

      // Conflict on index 4 with a dirty victim.
      do_op(0, 30'h111, 32'd0);
      chk("wb_addr_lit", last_wr_addr, 28'h4);
      chk("wb_word1_lit", last_wr_data[63:32], 32'hDEAD_BEEF);
      chk("wb_fill_lit", last_rd_addr, 28'h44);
      chk("wb_cyc", op_cyc, 7);

      // Write miss to clean index 2, then a conflicting read.
      do_op(1, 30'h08, 32'h1234_5678);
      chk("wmiss_traffic", {n_rd[3:0], n_wr[3:0]}, 8'h10);
      chk("wmiss_addr", last_rd_addr, 28'h2);
      do_op(0, 30'h108, 32'd0);
      chk("wmiss_wb_addr", last_wr_addr, 28'h2);
      chk("wmiss_wb_word0", last_wr_data[31:0], 32'h1234_5678);
      chk("wmiss_fill", last_rd_addr, 28'h42);

      // Reset in the middle of an allocate.
      mem_lat = 10;
      proc_addr = 30'h10; proc_read = 1;
      repeat (3) @(negedge clk);
      chk("alloc_active", mem_read, 1'b1);
      mon_en = 0;
      rst_n = 1'b0;
      #1;
      chk("rst_drop_read", mem_read, 1'b0);
      chk("rst_drop_stall", proc_stall, 1'b0);
      chk("rst_drop_rdata", proc_rdata, 32'd0);
      @(posedge clk);
      #1;
      proc_read = 0;
      @(negedge clk) rst_n = 1'b1;
      golden.delete();
      for (int k = 0; k < 8; k++) begin m_valid[k] = 0; m_dirty[k] = 0; end
      @(posedge clk);
      #1;
      mon_en = 1;
      do_op(0, 30'h10, 32'd0);
      chk("post_rst_cyc", op_cyc, 11);

      // Random traffic at two latencies with stray mem_ready pulses.
      for (int p = 0; p < 2; p++) begin
         mem_lat = (p == 0) ? 1 : 10;
         for (int k = 0; k < 100; k++) begin
            ra = (30'($urandom_range(0, 3)) << 5) | 30'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) do_op(1, ra, $urandom);
            else do_op(0, ra, 32'd0);
            if (k % 10 == 0) begin
               spurious = 1;
               repeat (3) @(posedge clk);
               #1;
            end
         end
      end

      // Read back every address the random phase could touch.
      mem_lat = 2;
      for (int k = 0; k < 128; k++) do_op(0, 30'(k), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
